// File: rtl/auc_wmul_loop.sv
// Main scan loop of the windowed scalar multiplier.
// Walks scalar K from MSB to LSB using sliding windows of at most 3 bits with
// odd digits (1, 3, 5, 7). For each window it either copies the odd-multiple
// table entry into the accumulator (first nonzero window) or issues the
// doubles for the window length followed by one add of the table entry.
module auc_wmul_loop #(
  parameter int WIDTH = 256,
  parameter int ADDR  = 5,
  parameter int IDXW  = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mul_en,
  input  logic [WIDTH-1:0] mul_k,
  input  logic             mul_dbl_end,
  input  logic             mul_add_end,
  output logic             mul_dbl_en,
  output logic             mul_add_en,
  output logic [ADDR-1:0]  mul_paddx,
  output logic [ADDR-1:0]  mul_paddy,
  output logic [ADDR-1:0]  mul_paddz,
  output logic             mul_dbl,
  output logic             mul_ram_1st,
  output logic             mul_done,
  output logic             mul_inf,
  output logic [ADDR-1:0]  mul_radd,
  input  logic [WIDTH-1:0] mul_rdat,
  output logic             mul_wen,
  output logic [ADDR-1:0]  mul_wadd,
  output logic [WIDTH-1:0] mul_wdat
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SCAN     = 4'd1;
  localparam logic [3:0] S_RD_X     = 4'd2;
  localparam logic [3:0] S_WR_X     = 4'd3;
  localparam logic [3:0] S_RD_Y     = 4'd4;
  localparam logic [3:0] S_WR_Y     = 4'd5;
  localparam logic [3:0] S_RD_Z     = 4'd6;
  localparam logic [3:0] S_WR_Z     = 4'd7;
  localparam logic [3:0] S_DBL_GO   = 4'd8;
  localparam logic [3:0] S_DBL_WAIT = 4'd9;
  localparam logic [3:0] S_ADD_GO   = 4'd10;
  localparam logic [3:0] S_ADD_WAIT = 4'd11;
  localparam logic [3:0] S_FIN      = 4'd12;

  // Accumulator slots in the shared RAM
  localparam logic [ADDR-1:0] TEMP0 = ADDR'(20);
  localparam logic [ADDR-1:0] TEMP1 = ADDR'(21);
  localparam logic [ADDR-1:0] TEMP2 = ADDR'(22);

  localparam logic signed [IDXW-1:0] IDX_TOP = IDXW'(WIDTH - 1);
  localparam logic signed [IDXW-1:0] IDX_ONE = IDXW'(1);

  // Digit code d selects odd multiple u = 2*d+1 (G, 3G, 5G, 7G)
  function automatic logic [ADDR-1:0] tab_x(input logic [1:0] d);
    case (d)
      2'd0:    tab_x = ADDR'(0);
      2'd1:    tab_x = ADDR'(2);
      2'd2:    tab_x = ADDR'(5);
      default: tab_x = ADDR'(8);
    endcase
  endfunction

  function automatic logic [ADDR-1:0] tab_y(input logic [1:0] d);
    case (d)
      2'd0:    tab_y = ADDR'(1);
      2'd1:    tab_y = ADDR'(3);
      2'd2:    tab_y = ADDR'(6);
      default: tab_y = ADDR'(9);
    endcase
  endfunction

  function automatic logic [ADDR-1:0] tab_z(input logic [1:0] d);
    case (d)
      2'd0:    tab_z = ADDR'(19);
      2'd1:    tab_z = ADDR'(4);
      2'd2:    tab_z = ADDR'(7);
      default: tab_z = ADDR'(10);
    endcase
  endfunction

  logic [3:0]              state;
  logic signed [IDXW-1:0]  idx;
  logic [WIDTH-1:0]        k;
  logic                    acc_inf;
  logic [1:0]              dbl_cnt;
  logic                    add_pend;
  logic [1:0]              digit;
  logic                    inf_hold;

  logic [IDXW-1:0]         idx_u;
  logic [2:0]              win;
  logic [1:0]              win_len;
  logic [1:0]              win_digit;
  logic signed [IDXW-1:0]  len_s;

  assign idx_u = $unsigned(idx);

  // Window decode: win[2]=k[i], win[1]=k[i-1], win[0]=k[i-2]; bits below
  // index 0 come from the zero padding, which covers the i<2 guards.
  always_comb begin
    win       = 3'({k, 2'b00} >> idx_u);
    win_len   = 2'd1;
    win_digit = 2'd0;
    if (win[2] && win[0]) begin
      win_len   = 2'd3;
      win_digit = {1'b1, win[1]};
    end else if (win[1]) begin
      win_len   = 2'd2;
      win_digit = 2'd1;
    end
    len_s = $signed({{(IDXW-2){1'b0}}, win_len});
  end

  // Scan FSM, window bookkeeping and held add operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      k         <= '0;
      acc_inf   <= 1'b1;
      dbl_cnt   <= 2'd0;
      add_pend  <= 1'b0;
      digit     <= 2'd0;
      mul_paddx <= '0;
      mul_paddy <= '0;
      mul_paddz <= '0;
      inf_hold  <= 1'b0;
    end else if (mul_en) begin
      state     <= S_SCAN;
      idx       <= IDX_TOP;
      k         <= mul_k;
      acc_inf   <= 1'b1;
      dbl_cnt   <= 2'd0;
      add_pend  <= 1'b0;
      digit     <= 2'd0;
      mul_paddx <= '0;
      mul_paddy <= '0;
      mul_paddz <= '0;
      inf_hold  <= 1'b0;
    end else begin
      case (state)
        S_SCAN: begin
          if (idx[IDXW-1]) begin
            state <= S_FIN;
          end else if (!win[2]) begin
            idx <= idx - IDX_ONE;
            if (!acc_inf) begin
              dbl_cnt  <= 2'd1;
              add_pend <= 1'b0;
              state    <= S_DBL_GO;
            end
          end else begin
            idx   <= idx - len_s;
            digit <= win_digit;
            if (acc_inf) begin
              acc_inf <= 1'b0;
              state   <= S_RD_X;
            end else begin
              dbl_cnt  <= win_len;
              add_pend <= 1'b1;
              state    <= S_DBL_GO;
            end
          end
        end
        S_RD_X:   state <= S_WR_X;
        S_WR_X:   state <= S_RD_Y;
        S_RD_Y:   state <= S_WR_Y;
        S_WR_Y:   state <= S_RD_Z;
        S_RD_Z:   state <= S_WR_Z;
        S_WR_Z:   state <= S_SCAN;
        S_DBL_GO: state <= S_DBL_WAIT;
        S_DBL_WAIT: begin
          if (mul_dbl_end) begin
            dbl_cnt <= dbl_cnt - 2'd1;
            if (dbl_cnt != 2'd1) begin
              state <= S_DBL_GO;
            end else if (add_pend) begin
              mul_paddx <= tab_x(digit);
              mul_paddy <= tab_y(digit);
              mul_paddz <= tab_z(digit);
              state     <= S_ADD_GO;
            end else begin
              state <= S_SCAN;
            end
          end
        end
        S_ADD_GO: state <= S_ADD_WAIT;
        S_ADD_WAIT: begin
          if (mul_add_end) state <= S_SCAN;
        end
        S_FIN: begin
          inf_hold <= acc_inf;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Command pulses, RAM port and status decoded from the current state
  always_comb begin
    mul_dbl_en  = 1'b0;
    mul_add_en  = 1'b0;
    mul_dbl     = 1'b0;
    mul_ram_1st = 1'b0;
    mul_done    = 1'b0;
    mul_radd    = '0;
    mul_wen     = 1'b0;
    mul_wadd    = '0;
    mul_inf     = inf_hold;
    case (state)
      S_RD_X: begin mul_ram_1st = 1'b1; mul_radd = tab_x(digit); end
      S_WR_X: begin mul_ram_1st = 1'b1; mul_wen = 1'b1; mul_wadd = TEMP0; end
      S_RD_Y: begin mul_ram_1st = 1'b1; mul_radd = tab_y(digit); end
      S_WR_Y: begin mul_ram_1st = 1'b1; mul_wen = 1'b1; mul_wadd = TEMP1; end
      S_RD_Z: begin mul_ram_1st = 1'b1; mul_radd = tab_z(digit); end
      S_WR_Z: begin mul_ram_1st = 1'b1; mul_wen = 1'b1; mul_wadd = TEMP2; end
      S_DBL_GO:   begin mul_dbl_en = 1'b1; mul_dbl = 1'b1; end
      S_DBL_WAIT: mul_dbl = 1'b1;
      S_ADD_GO:   mul_add_en = 1'b1;
      S_FIN:      begin mul_done = 1'b1; mul_inf = acc_inf; end
      default: ;
    endcase
  end

  assign mul_wdat = mul_rdat;

endmodule

// File: tb/tb_auc_wmul_loop.sv
// Directed bench for auc_wmul_loop: point-unit responder, event log of
// copies/commands/completions, and expected event sequences per scalar.
module tb_auc_wmul_loop;
  localparam int WIDTH = 256;
  localparam int ADDR  = 5;
  localparam int IDXW  = 9;

  logic             clk;
  logic             rst_n;
  logic             mul_en;
  logic [WIDTH-1:0] mul_k;
  logic             mul_dbl_end;
  logic             mul_add_end;
  logic             mul_dbl_en;
  logic             mul_add_en;
  logic [ADDR-1:0]  mul_paddx;
  logic [ADDR-1:0]  mul_paddy;
  logic [ADDR-1:0]  mul_paddz;
  logic             mul_dbl;
  logic             mul_ram_1st;
  logic             mul_done;
  logic             mul_inf;
  logic [ADDR-1:0]  mul_radd;
  logic [WIDTH-1:0] mul_rdat;
  logic             mul_wen;
  logic [ADDR-1:0]  mul_wadd;
  logic [WIDTH-1:0] mul_wdat;

  auc_wmul_loop #(.WIDTH(WIDTH), .ADDR(ADDR), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .mul_en(mul_en), .mul_k(mul_k),
    .mul_dbl_end(mul_dbl_end), .mul_add_end(mul_add_end),
    .mul_dbl_en(mul_dbl_en), .mul_add_en(mul_add_en),
    .mul_paddx(mul_paddx), .mul_paddy(mul_paddy), .mul_paddz(mul_paddz),
    .mul_dbl(mul_dbl), .mul_ram_1st(mul_ram_1st), .mul_done(mul_done),
    .mul_inf(mul_inf), .mul_radd(mul_radd), .mul_rdat(mul_rdat),
    .mul_wen(mul_wen), .mul_wadd(mul_wadd), .mul_wdat(mul_wdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ev[$];
  int dly   = 3;
  bit spur  = 1'b0;

  // Event log: 500+radd on reads, wadd on writes, 99 per double,
  // 1xxyyzz per add, 7000+inf on done
  always @(negedge clk) begin
    if (mul_ram_1st && !mul_wen) ev.push_back(500 + int'(mul_radd));
    if (mul_wen) ev.push_back(int'(mul_wadd));
    if (mul_dbl_en) ev.push_back(99);
    if (mul_add_en)
      ev.push_back(1000000 + int'(mul_paddx) * 10000 + int'(mul_paddy) * 100 + int'(mul_paddz));
    if (mul_done) ev.push_back(7000 + int'(mul_inf));
  end

  // Point-unit responder: *_end pulse dly+1 cycles after each start pulse,
  // optionally with a stray mul_add_end in the middle of a double
  initial begin
    int dcnt;
    int acnt;
    dcnt = -1;
    acnt = -1;
    mul_dbl_end = 1'b0;
    mul_add_end = 1'b0;
    forever begin
      @(negedge clk);
      mul_dbl_end = 1'b0;
      mul_add_end = 1'b0;
      if (dcnt == 0) begin
        mul_dbl_end = 1'b1;
        dcnt = -1;
      end else if (dcnt > 0) begin
        if (spur && dcnt == dly - 5) mul_add_end = 1'b1;
        dcnt--;
      end
      if (acnt == 0) begin
        mul_add_end = 1'b1;
        acnt = -1;
      end else if (acnt > 0) begin
        acnt--;
      end
      if (mul_dbl_en) dcnt = dly;
      if (mul_add_en) acnt = dly;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [WIDTH-1:0] kval);
    mul_k  = kval;
    mul_en = 1'b1;
    tick();
    mul_en = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (!mul_done && cyc < budget) begin
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(mul_done), 64'd1);
  endtask

  task automatic check_seq(input string tag, input int base, input int exp[$]);
    check({tag, "_len"}, 64'(ev.size() - base), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < ev.size()) check({tag, "_ev"}, 64'(ev[base + i]), 64'(exp[i]));
      else check({tag, "_ev_missing"}, 64'hFFFF_FFFF, 64'(exp[i]));
    end
  endtask

  task automatic wait_high(input string tag, input int budget, input bit which);
    int n;
    n = 0;
    while (!(which ? mul_dbl : mul_wen) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_reached"}, 64'(which ? mul_dbl : mul_wen), 64'd1);
  endtask

  initial begin
    int base;
    int cyc;
    rst_n    = 1'b0;
    mul_en   = 1'b0;
    mul_k    = '0;
    mul_rdat = '0;
    tick();
    tick();

    // Reset state
    check("rst_done", 64'(mul_done), 64'd0);
    check("rst_inf", 64'(mul_inf), 64'd0);
    check("rst_dbl", 64'(mul_dbl), 64'd0);
    check("rst_wen", 64'(mul_wen), 64'd0);
    check("rst_radd", 64'(mul_radd), 64'd0);
    check("rst_paddz", 64'(mul_paddz), 64'd0);
    rst_n = 1'b1;
    tick();

    // K=0: no activity, done after WIDTH+1 cycles, result at infinity
    base = ev.size();
    start('0);
    wait_done("k0", 400, cyc);
    check("k0_latency", 64'(cyc), 64'(WIDTH + 1));
    check("k0_inf", 64'(mul_inf), 64'd1);
    check_seq("k0", base, '{7001});
    tick();
    check("k0_done_pulse", 64'(mul_done), 64'd0);
    check("k0_inf_hold", 64'(mul_inf), 64'd1);

    // K=1: single copy of G
    mul_rdat = {4{64'h0123_4567_89AB_CDEF}};
    base = ev.size();
    start(256'd1);
    wait_high("k1_wen", 400, 1'b0);
    check("k1_wdat", 64'(mul_wdat[63:0]), 64'h0123_4567_89AB_CDEF);
    wait_done("k1", 400, cyc);
    check("k1_inf", 64'(mul_inf), 64'd0);
    check_seq("k1", base, '{500, 20, 501, 21, 519, 22, 7000});

    // K=13: copy 3G, two doubles, add G
    base = ev.size();
    start(256'd13);
    wait_done("k13", 600, cyc);
    check("k13_dbl_low", 64'(mul_dbl), 64'd0);
    check_seq("k13", base, '{502, 20, 503, 21, 504, 22, 99, 99, 1000119, 7000});

    // K=23: copy 5G, two doubles, add 3G
    base = ev.size();
    start(256'd23);
    wait_done("k23", 600, cyc);
    check_seq("k23", base, '{505, 20, 506, 21, 507, 22, 99, 99, 1020304, 7000});
    check("k23_paddx_held", 64'(mul_paddx), 64'd2);

    // K=15: copy 7G, one double, add G
    base = ev.size();
    start(256'd15);
    wait_done("k15", 600, cyc);
    check_seq("k15", base, '{508, 20, 509, 21, 510, 22, 99, 1000119, 7000});

    // Slow double with a stray add_end while waiting
    dly  = 20;
    spur = 1'b1;
    base = ev.size();
    start(256'd13);
    wait_high("spur_dbl", 400, 1'b1);
    repeat (12) tick();
    check("spur_dbl_held", 64'(mul_dbl), 64'd1);
    check("spur_no_extra", 64'(ev.size() - base), 64'd7);
    check("spur_add_en", 64'(mul_add_en), 64'd0);
    wait_done("spur", 800, cyc);
    check_seq("spur", base, '{502, 20, 503, 21, 504, 22, 99, 99, 1000119, 7000});
    spur = 1'b0;

    // Restart with K=1 while a double of K=13 is outstanding
    start(256'd13);
    wait_high("rs_dbl", 400, 1'b1);
    repeat (3) tick();
    base = ev.size();
    start(256'd1);
    check("rs_dbl_drop", 64'(mul_dbl), 64'd0);
    wait_done("rs", 400, cyc);
    check_seq("rs", base, '{500, 20, 501, 21, 519, 22, 7000});
    repeat (30) tick();
    check("rs_stale_quiet", 64'(ev.size() - base), 64'd7);
    dly = 3;

    // Asynchronous reset in the middle of a copy
    start(256'd1);
    wait_high("ar_wen", 400, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_wen", 64'(mul_wen), 64'd0);
    check("ar_ram_1st", 64'(mul_ram_1st), 64'd0);
    check("ar_wadd", 64'(mul_wadd), 64'd0);
    check("ar_radd", 64'(mul_radd), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Recovery after reset
    base = ev.size();
    start(256'd15);
    wait_done("rec", 600, cyc);
    check_seq("rec", base, '{508, 20, 509, 21, 510, 22, 99, 1000119, 7000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
